serial_word_deserializer: RTL and testbench

SERIAL_WORD_DESERIALIZER -- requirements
Module: serial_word_deserializer

---
 rtl/serial_pkg.sv | 11 +
 rtl/deser_out_stage.sv | 45 ++++
 rtl/serial_word_deserializer.sv | 126 ++++++++++++
 tb/tb_serial_word_deserializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial word deserializer: FSM states and default word width.
package serial_pkg;

  typedef enum logic {
    StHunt    = 1'b0,
    StCollect = 1'b1
  } deser_state_e;

  localparam int unsigned DefaultDataWidth = 4;

endpackage

// File: rtl/deser_out_stage.sv
// Output holding register with valid/ready handshake; reports load acceptance combinationally.
module deser_out_stage #(
  parameter int unsigned DATA_WIDTH = serial_pkg::DefaultDataWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  accept
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  // A new word fits if the register is empty or is being drained this cycle.
  assign accept = load & (~valid_q | out_ready);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (accept) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// LSB-first serial-to-parallel word assembler with sync framing, output handshake and
// sticky overflow / framing-error flags plus a saturating drop counter.
module serial_word_deserializer #(
  parameter int unsigned DATA_WIDTH = serial_pkg::DefaultDataWidth,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  sync,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  err_clear,
  output logic                  overflow,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  import serial_pkg::*;

  localparam int unsigned IdxW = $clog2(DATA_WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  deser_state_e          state_q, state_d;
  logic [IdxW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d, drop_base;

  logic                  word_done;
  logic                  frame_evt;
  logic                  drop_evt;
  logic                  accept;
  logic [DATA_WIDTH-1:0] done_word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    word_done = 1'b0;
    frame_evt = 1'b0;
    done_word = word_q;
    done_word[DATA_WIDTH-1] = bit_in;
    if (bit_valid) begin
      unique case (state_q)
        StHunt: begin
          if (sync) begin
            word_d    = '0;
            word_d[0] = bit_in;
            cnt_d     = IdxW'(1);
            state_d   = StCollect;
          end
        end
        StCollect: begin
          // A sync inside a word wins over completion: the partial word is abandoned.
          if (sync) begin
            frame_evt = 1'b1;
            word_d    = '0;
            word_d[0] = bit_in;
            cnt_d     = IdxW'(1);
          end else if (cnt_q == LastIdx) begin
            word_done = 1'b1;
            word_d    = '0;
            cnt_d     = '0;
            state_d   = StHunt;
          end else begin
            word_d[cnt_q] = bit_in;
            cnt_d         = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Error bookkeeping: a same-cycle event overrides err_clear.
  always_comb begin
    drop_evt    = word_done & ~accept;
    overflow_d  = (overflow_q & ~err_clear) | drop_evt;
    frame_err_d = (frame_err_q & ~err_clear) | frame_evt;
    drop_base   = err_clear ? '0 : drop_q;
    drop_d      = drop_base;
    if (drop_evt && (drop_base != '1)) begin
      drop_d = drop_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      cnt_q       <= '0;
      word_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      drop_q      <= drop_d;
    end
  end

  deser_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (word_done),
    .load_data (done_word),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .accept    (accept)
  );

  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench: a bit-list reference model queues expected words, a monitor checks outputs.
module tb_serial_word_deserializer;

  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          sync = 1'b0;
  logic          out_ready = 1'b0;
  logic          err_clear = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          overflow;
  logic          frame_err;
  logic [CW-1:0] drop_count;

  serial_word_deserializer #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .sync       (sync),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_clear  (err_clear),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  // Reference model state: bits received since sync, output occupancy, flags.
  int m_bits[$];
  int exp_q[$];
  bit m_valid = 1'b0;
  bit m_ovf = 1'b0;
  bit m_fe = 1'b0;
  int m_drop = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit bv, input bit sy, input bit b,
                            input bit rdy, input bit clr);
    bit done;
    bit acc;
    int word;
    if (r) begin
      m_bits.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_ovf = 1'b0;
      m_fe = 1'b0;
      m_drop = 0;
      return;
    end
    done = 1'b0;
    word = 0;
    if (clr) begin
      m_ovf = 1'b0;
      m_fe = 1'b0;
      m_drop = 0;
    end
    if (bv) begin
      if (sy) begin
        if (m_bits.size() != 0) m_fe = 1'b1;
        m_bits.delete();
        m_bits.push_back(int'(b));
      end else if (m_bits.size() != 0) begin
        m_bits.push_back(int'(b));
      end
      if (m_bits.size() == DW) begin
        done = 1'b1;
        for (int i = 0; i < DW; i++) word += m_bits[i] << i;
        m_bits.delete();
      end
    end
    acc = done && (!m_valid || rdy);
    if (done && !acc) begin
      m_ovf = 1'b1;
      if (m_drop < (1 << CW) - 1) m_drop++;
    end
    if (acc) begin
      m_valid = 1'b1;
      exp_q.push_back(word);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input bit bv, input bit sy, input bit b, input bit rdy,
                     input bit clr, input bit r);
    bit_valid = bv;
    sync = sy;
    bit_in = b;
    out_ready = rdy;
    err_clear = clr;
    rst = r;
    @(posedge clk);
    #1;
    model_step(r, bv, sy, b, rdy, clr);
  endtask

  task automatic send_word(input int w, input int gap, input bit rdy);
    for (int i = 0; i < DW; i++) begin
      if (i > 0) repeat (gap) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
      cyc(1'b1, i == 0, w[i], rdy, 1'b0, 1'b0);
    end
  endtask

  // Monitor: flags every cycle, popped expected word on each transfer.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("frame_err", int'(frame_err), int'(m_fe));
      chk("drop_count", int'(drop_count), m_drop);
      if (out_valid && out_ready) begin
        chk("xfer_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("xfer_data", int'(out_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    int w;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_drop", int'(drop_count), 0);
    mon_en = 1'b1;

    // Basic word, ready high.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(32'hB, 0, 1'b1);
    chk("s1_data", int'(out_data), 32'hB);
    chk("s1_valid", int'(out_valid), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s1_drained", int'(out_valid), 0);

    // Same word with idle gaps between bits.
    w = 32'hB;
    for (int i = 0; i < DW; i++) begin
      if (i > 0) repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == DW - 1) chk("s2_no_early", int'(out_valid), 0);
      cyc(1'b1, i == 0, w[i], 1'b1, 1'b0, 1'b0);
    end
    chk("s2_data", int'(out_data), 32'hB);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: second word is dropped, first stays.
    send_word(32'h3, 0, 1'b0);
    send_word(32'h5, 0, 1'b0);
    chk("s3_hold", int'(out_data), 32'h3);
    chk("s3_ovf", int'(overflow), 1);
    chk("s3_drop", int'(drop_count), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s3_xfer", int'(out_valid), 0);

    // Sync mid-word.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(32'h8, 0, 1'b0);
    chk("s4_fe", int'(frame_err), 1);
    chk("s4_data", int'(out_data), 32'h8);

    // Reset mid-word.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(32'hC, 0, 1'b0);
    chk("s5_data", int'(out_data), 32'hC);
    chk("s5_fe", int'(frame_err), 0);
    chk("s5_ovf", int'(overflow), 0);

    // Drop counter saturation, then clear; clear racing a drop.
    for (int k = 0; k < 260; k++) send_word(k & 15, 0, 1'b0);
    chk("s6_sat", int'(drop_count), 255);
    chk("s6_data", int'(out_data), 32'hC);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s6_clr_drop", int'(drop_count), 0);
    chk("s6_clr_ovf", int'(overflow), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s7_clr_race_drop", int'(drop_count), 1);
    chk("s7_clr_race_ovf", int'(overflow), 1);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom % 4) != 0, ($urandom % 6) == 0, 1'($urandom), ($urandom % 3) != 0,
          ($urandom % 60) == 0, ($urandom % 500) == 0);
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
